// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, data port and shared memory port of mem_arbiter.
// The arbiter connects through "slave"; the requesters and memory model drive through "master".
interface mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic              i_if_req;
   logic [ADDR_W-1:0] i_if_addr;
   logic              o_if_ready;
   logic [DATA_W-1:0] o_if_data;
   logic              i_d_req;
   logic              i_d_rw;
   logic [ADDR_W-1:0] i_d_addr;
   logic [DATA_W-1:0] i_d_wdata;
   logic              o_d_ready;
   logic [DATA_W-1:0] o_d_rdata;
   logic              o_err;
   logic              o_mem_req;
   logic [ADDR_W-1:0] o_mem_addr;
   logic              o_mem_rw;
   logic [DATA_W-1:0] o_mem_wdata;
   logic              i_mem_ack;
   logic [DATA_W-1:0] i_mem_rdata;

   modport slave (
      input  i_if_req, i_if_addr,
      output o_if_ready, o_if_data,
      input  i_d_req, i_d_rw, i_d_addr, i_d_wdata,
      output o_d_ready, o_d_rdata, o_err,
      output o_mem_req, o_mem_addr, o_mem_rw, o_mem_wdata,
      input  i_mem_ack, i_mem_rdata
   );

   modport master (
      output i_if_req, i_if_addr,
      input  o_if_ready, o_if_data,
      output i_d_req, i_d_rw, i_d_addr, i_d_wdata,
      input  o_d_ready, o_d_rdata, o_err,
      input  o_mem_req, o_mem_addr, o_mem_rw, o_mem_wdata,
      output i_mem_ack, i_mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one shared memory port: data has priority, but a pending fetch
// is served after MAX_DATA_BURST consecutive data grants. Unacked transactions time out.
module mem_arbiter #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 32,
   parameter int MAX_DATA_BURST = 4,
   parameter int TIMEOUT        = 16
) (
   input logic          i_clk,
   input logic          i_reset,
   mem_arbiter_if.slave bus
);
   localparam int ST_W = $clog2(MAX_DATA_BURST + 1);
   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_D  = 2'd2
   } state_t;

   state_t            state_r, state_s;
   logic [ST_W-1:0]   starve_r, starve_s;
   logic [TO_W-1:0]   to_cnt_r, to_cnt_s;
   logic              mem_req_r, mem_req_s;
   logic              mem_rw_r, mem_rw_s;
   logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
   logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
   logic              if_ready_r, if_ready_s;
   logic              d_ready_r, d_ready_s;
   logic              err_r, err_s;
   logic [DATA_W-1:0] if_data_r, if_data_s;
   logic [DATA_W-1:0] d_rdata_r, d_rdata_s;
   logic              grant_if_s, grant_d_s, done_s, timeout_s;

   // Next-state, arbitration, starvation and completion logic
   always_comb begin
      state_s     = state_r;
      starve_s    = starve_r;
      to_cnt_s    = to_cnt_r;
      mem_req_s   = mem_req_r;
      mem_rw_s    = mem_rw_r;
      mem_addr_s  = mem_addr_r;
      mem_wdata_s = mem_wdata_r;
      if_ready_s  = 1'b0;
      d_ready_s   = 1'b0;
      err_s       = 1'b0;
      if_data_s   = {DATA_W{1'b0}};
      d_rdata_s   = {DATA_W{1'b0}};
      grant_if_s  = 1'b0;
      grant_d_s   = 1'b0;
      done_s      = 1'b0;
      timeout_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.i_if_req && (!bus.i_d_req || (starve_r == ST_W'(MAX_DATA_BURST)))) begin
               grant_if_s = 1'b1;
            end else if (bus.i_d_req) begin
               grant_d_s = 1'b1;
            end else begin
               grant_d_s = 1'b0;
            end
            if (grant_if_s) begin
               state_s     = BUSY_IF;
               mem_req_s   = 1'b1;
               mem_addr_s  = bus.i_if_addr;
               mem_rw_s    = 1'b1;
               mem_wdata_s = {DATA_W{1'b0}};
               to_cnt_s    = {TO_W{1'b0}};
               starve_s    = {ST_W{1'b0}};
            end else if (grant_d_s) begin
               state_s     = BUSY_D;
               mem_req_s   = 1'b1;
               mem_addr_s  = bus.i_d_addr;
               mem_rw_s    = bus.i_d_rw;
               mem_wdata_s = bus.i_d_wdata;
               to_cnt_s    = {TO_W{1'b0}};
               if (!bus.i_if_req) begin
                  starve_s = {ST_W{1'b0}};
               end else if (starve_r != ST_W'(MAX_DATA_BURST)) begin
                  starve_s = starve_r + ST_W'(1);
               end else begin
                  starve_s = starve_r;
               end
            end else if (!bus.i_if_req) begin
               starve_s = {ST_W{1'b0}};
            end else begin
               starve_s = starve_r;
            end
         end
         BUSY_IF, BUSY_D: begin
            // An ack in the expiry cycle still counts as a normal completion
            if (bus.i_mem_ack) begin
               done_s = 1'b1;
            end else if (to_cnt_r == TO_W'(TIMEOUT - 1)) begin
               timeout_s = 1'b1;
            end else begin
               to_cnt_s = to_cnt_r + TO_W'(1);
            end
            if (done_s || timeout_s) begin
               state_s   = IDLE;
               mem_req_s = 1'b0;
               err_s     = timeout_s;
               if (state_r == BUSY_IF) begin
                  if_ready_s = 1'b1;
                  if_data_s  = done_s ? bus.i_mem_rdata : {DATA_W{1'b0}};
               end else begin
                  d_ready_s = 1'b1;
                  d_rdata_s = (done_s && mem_rw_r) ? bus.i_mem_rdata : {DATA_W{1'b0}};
               end
            end else begin
               state_s = state_r;
            end
         end
         default: begin
            state_s   = IDLE;
            mem_req_s = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r     <= IDLE;
         starve_r    <= {ST_W{1'b0}};
         to_cnt_r    <= {TO_W{1'b0}};
         mem_req_r   <= 1'b0;
         mem_rw_r    <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= {DATA_W{1'b0}};
         if_ready_r  <= 1'b0;
         d_ready_r   <= 1'b0;
         err_r       <= 1'b0;
         if_data_r   <= {DATA_W{1'b0}};
         d_rdata_r   <= {DATA_W{1'b0}};
      end else begin
         state_r     <= state_s;
         starve_r    <= starve_s;
         to_cnt_r    <= to_cnt_s;
         mem_req_r   <= mem_req_s;
         mem_rw_r    <= mem_rw_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
         if_ready_r  <= if_ready_s;
         d_ready_r   <= d_ready_s;
         err_r       <= err_s;
         if_data_r   <= if_data_s;
         d_rdata_r   <= d_rdata_s;
      end
   end

   assign bus.o_mem_req   = mem_req_r;
   assign bus.o_mem_rw    = mem_rw_r;
   assign bus.o_mem_addr  = mem_addr_r;
   assign bus.o_mem_wdata = mem_wdata_r;
   assign bus.o_if_ready  = if_ready_r;
   assign bus.o_if_data   = if_data_r;
   assign bus.o_d_ready   = d_ready_r;
   assign bus.o_d_rdata   = d_rdata_r;
   assign bus.o_err       = err_r;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- ADDR_W, 16, address width.
- DATA_W, 32, data width.
- MAX_DATA_BURST, 4, maximum consecutive data grants while a fetch request is pending.
- TIMEOUT, 16, cycles to wait for i_mem_ack before aborting a transaction.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- i_clk, in, 1, clock; all state changes on the rising edge.
- i_reset, in, 1, reset; synchronous, active-high.
- i_if_req, in, 1, instruction-fetch request; read-only.
- i_if_addr, in, ADDR_W, fetch address.
- o_if_ready, out, 1, one-cycle fetch completion pulse.
- o_if_data, out, DATA_W, fetched word; valid while o_if_ready=1.
- i_d_req, in, 1, data request.
- i_d_rw, in, 1, data direction; 1=read, 0=write.
- i_d_addr, in, ADDR_W, data address.
- i_d_wdata, in, DATA_W, write data.
- o_d_ready, out, 1, one-cycle data completion pulse.
- o_d_rdata, out, DATA_W, read data; valid while o_d_ready=1.
- o_err, out, 1, timeout flag; valid with either ready pulse.
- o_mem_req, out, 1, shared memory port request.
- o_mem_addr, out, ADDR_W, memory address.
- o_mem_rw, out, 1, memory direction; 1=read.
- o_mem_wdata, out, DATA_W, memory write data.
- i_mem_ack, in, 1, memory completion; i_mem_rdata is valid in the same cycle.
- i_mem_rdata, in, DATA_W, memory read data.

Function
REQ-003 The FSM SHALL have exactly three states:
- IDLE.
- BUSY_IF.
- BUSY_D.

REQ-004 In IDLE, the arbiter SHALL sample the requests each cycle.
- If only one requester is active, that requester is granted.
- If both are active, data wins unless starve_cnt == MAX_DATA_BURST, in which case fetch wins.
- The FSM moves to BUSY_IF or BUSY_D on the next edge.

REQ-005 On the grant edge, the block SHALL register the following; they remain stable until the transaction ends:
- o_mem_addr, o_mem_rw and o_mem_wdata.
- o_mem_req=1.
- For a fetch, o_mem_rw=1 and o_mem_wdata=0.

REQ-006 A request sampled in IDLE in cycle N SHALL produce o_mem_req=1 in cycle N+1.

REQ-007 i_mem_ack SHALL be ignored when the FSM is in IDLE.

REQ-008 On i_mem_ack in a BUSY state in cycle M, the block SHALL do all of the following at edge M→M+1:
- Drop o_mem_req.
- Pulse the owning requester's ready for exactly cycle M+1 with the captured i_mem_rdata (write completions output 0) and o_err=0.
- Return to IDLE.

REQ-009 Minimum request-to-ready latency SHALL be 2 cycles (ack in the first o_mem_req cycle); minimum spacing between grants SHALL be one IDLE cycle.

REQ-010 A timeout counter SHALL behave as follows:
- It clears on grant and increments each BUSY cycle without ack.
- When it reaches TIMEOUT-1 without ack, the block drops o_mem_req, pulses the owner's ready with data 0 and o_err=1, and returns to IDLE.
- An ack in that same cycle takes precedence, giving a normal completion.

REQ-011 starve_cnt SHALL behave as follows:
- Increments (saturating at MAX_DATA_BURST) on each data grant made while i_if_req=1.
- Clears on any fetch grant.
- Clears on any IDLE cycle with i_if_req=0.

REQ-012 Requesters SHALL hold req, address and data stable until their ready pulse; if a requester deasserts req mid-transaction, the transaction still completes and the ready pulse is still issued.

REQ-013 o_if_ready and o_d_ready SHALL never be high in the same cycle, and neither SHALL pulse unless preceded by a grant to that requester.

REQ-014 o_if_data, o_d_rdata and o_err SHALL be 0 whenever the corresponding ready is 0.

Reset
REQ-015 While i_reset=1 at a rising edge, the block SHALL:
- Enter IDLE.
- Clear starve_cnt and the timeout counter.
- Drive o_mem_req=0, o_if_ready=0, o_d_ready=0 and o_err=0.
- Drive every address and data output to 0.

REQ-016 Reset asserted mid-transaction SHALL abandon the transaction without a ready pulse; the first grant SHALL occur no earlier than the first edge after i_reset deasserts.

Verification
REQ-017 Single fetch: i_if_req=1, i_if_addr=0x0004, ack in the first o_mem_req cycle with rdata=0xDEADBEEF -> o_mem_addr=0x0004, o_mem_rw=1; o_if_ready pulses 2 cycles after the request with o_if_data=0xDEADBEEF.

REQ-018 Data write: i_d_req=1, i_d_rw=0, i_d_addr=0x0100, i_d_wdata=0x12345678, ack after 3 cycles -> o_mem_rw=0 and o_mem_wdata=0x12345678 held for 3 cycles; o_d_ready pulses once with o_d_rdata=0.

REQ-019 Contention: both requests held continuously, ack immediate -> grant order D,D,D,D,IF,D,D,D,D,IF.

REQ-020 Timeout: data read with no ack -> o_mem_req high for exactly 16 cycles, then o_d_ready=1, o_err=1, o_d_rdata=0.

REQ-021 Reset mid-transaction: i_reset=1 during BUSY_D -> next cycle o_mem_req=0 with no ready pulse; after release, a pending fetch is granted normally.

REQ-022 Late ack: an ack arriving in the same cycle the timeout expires -> normal completion with o_err=0 and valid data.
